// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Single-port data memory slave for a multicycle datapath. It holds DEPTH
//   32-bit words and serves one load or store at a time. Each access is
//   acknowledged with a one-cycle o_ready pulse. When the target address is
//   out of range, the pulse also raises o_err.
//
// Configuration:
//   DMEM_WAIT_EN  When defined, every access is stretched by WAIT wait
//                 states through a WAIT state and a down-counter. When it is
//                 undefined, the FSM goes straight from IDLE to DONE and
//                 o_ready rises in the cycle after acceptance.
//
// Parameters:
//   DEPTH         number of 32-bit words (power of two)
//   WAIT          wait states per access (0-15), used only with DMEM_WAIT_EN
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   reset         asynchronous active-low reset
//   i_req         access request, held high until o_ready is seen
//   i_we          1 = store, 0 = load, sampled with i_req
//   i_addr        word index of the access
//   i_write_data  store data
//   o_read_data   load result, held until the next completed load
//   o_ready       one-cycle completion pulse
//   o_err         out-of-range flag, only ever high together with o_ready
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH = 32,
    parameter int WAIT  = 2
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_ready,
    output logic        o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE,
        S_DONE
    } state_t;
`endif

    state_t        state_q;
    state_t        state_d;

    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   addr_q;
    logic [31:0]   wrData_q;
    logic          we_q;
    logic [31:0]   rdData_q;
    logic          ready_q;
    logic          err_q;

`ifdef DMEM_WAIT_EN
    logic [3:0]    cnt_q;
`endif

    logic          accept;
    logic          goDone;
    logic [31:0]   accAddr;
    logic [31:0]   accData;
    logic          accWe;
    logic [AW-1:0] accIdx;
    logic          accInRange;

    // The access that completes on this edge is described by the live inputs
    // while the FSM is still in IDLE. This is the zero-wait case, where the
    // accepting edge also enters DONE. Otherwise the access comes from the
    // registers captured at acceptance.
    // goDone marks the edge that enters DONE. Both the array write and the
    // load capture happen on that edge.
    always_comb begin
        accept = (state_q == S_IDLE) && i_req;

        if (state_q == S_IDLE) begin
            accAddr = i_addr;
            accData = i_write_data;
            accWe   = i_we;
        end else begin
            accAddr = addr_q;
            accData = wrData_q;
            accWe   = we_q;
        end

        accIdx     = accAddr[AW-1:0];
        accInRange = (accAddr[31:AW] == '0) && (32'(accIdx) < DEPTH);

`ifdef DMEM_WAIT_EN
        goDone = (accept && (WAIT == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == 4'd1));
`else
        goDone = accept;
`endif
    end

    // Next-state logic. DONE always falls back to IDLE, so a request that is
    // still held high is seen as a fresh access only after one IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
`ifdef DMEM_WAIT_EN
                    state_d = (WAIT > 0) ? S_WAIT : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Main sequential block. Reset clears control state and outputs, and
    // this aborts any access in flight. The array is written only inside the
    // non-reset branch, so a reset pulse can never corrupt it. The array
    // itself is deliberately left out of reset.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wrData_q <= '0;
            we_q     <= 1'b0;
            rdData_q <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= goDone;
            err_q   <= goDone && !accInRange;

            if (accept) begin
                addr_q   <= i_addr;
                wrData_q <= i_write_data;
                we_q     <= i_we;
            end

`ifdef DMEM_WAIT_EN
            if (accept) begin
                cnt_q <= 4'(WAIT);
            end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
`endif

            // Out-of-range stores are dropped and out-of-range loads return
            // zero. A store leaves the last load result untouched.
            if (goDone) begin
                if (accWe) begin
                    if (accInRange) begin
                        mem_q[accIdx] <= accData;
                    end
                end else begin
                    rdData_q <= accInRange ? mem_q[accIdx] : '0;
                end
            end
        end
    end

    assign o_read_data = rdData_q;
    assign o_ready     = ready_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder with DEPTH=32 and WAIT=2. Completion
// latency is 3 edges with DMEM_WAIT_EN defined and 1 edge without it,
// counting the acceptance edge as the first. The array contents are tracked
// in expMem and the last load result in lastRead.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 32;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        i_clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we  = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_write_data = '0;
    logic [31:0] o_read_data;
    logic        o_ready;
    logic        o_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expMem [DEPTH];
    logic [31:0] lastRead = '0;

    // Free-running 10 time-unit clock.
    always #5 i_clk = ~i_clk;

    dmem_responder #(
        .DEPTH(DEPTH),
        .WAIT (2)
    ) dut (
        .i_clk       (i_clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_write_data(i_write_data),
        .o_read_data (o_read_data),
        .o_ready     (o_ready),
        .o_err       (o_err)
    );

    // Counts one comparison, and counts and reports it if it fails.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one complete access. It checks the latency, the o_ready pulse,
    // o_err and o_read_data, then checks that the pulse ends after i_req is
    // dropped.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input string tag);
        int          edges;
        logic        inRange;
        logic [31:0] expRd;
        @(negedge i_clk);
        i_req = 1'b1;
        i_we = we;
        i_addr = addr;
        i_write_data = data;
        inRange = (addr < DEPTH);
        edges = 0;
        do begin
            @(posedge i_clk);
            #1;
            edges++;
        end while (!o_ready && edges < 20);
        checkOutput({tag, " latency"}, 32'(edges), 32'(LAT));
        checkOutput({tag, " ready"}, 32'(o_ready), 32'd1);
        checkOutput({tag, " err"}, 32'(o_err), 32'(!inRange));
        if (!we) begin
            expRd = inRange ? expMem[addr[4:0]] : 32'd0;
            lastRead = expRd;
        end else begin
            expRd = lastRead;
            if (inRange) expMem[addr[4:0]] = data;
        end
        checkOutput({tag, " rdata"}, o_read_data, expRd);
        @(negedge i_clk);
        i_req = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput({tag, " ready end"}, 32'(o_ready), 32'd0);
        checkOutput({tag, " err end"}, 32'(o_err), 32'd0);
    endtask

    initial begin
        int waitEdges;
        int first;
        int second;
        int pulses;

        // Reset is low from time zero, so every output must already be zero.
        #3;
        checkOutput("reset ready", 32'(o_ready), 32'd0);
        checkOutput("reset err", 32'(o_err), 32'd0);
        checkOutput("reset rdata", o_read_data, 32'd0);
        @(negedge i_clk);
        reset = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i), 32'h0101_0101 * 32'(i) + 32'h100, "prime");
        end

        // Store 96 to index 1, then read it back.
        applyStimulus(1'b1, 32'd1, 32'd96, "store1");
        applyStimulus(1'b0, 32'd1, 32'd0, "load1");

        // Loads return their own index's data, and o_read_data holds across a store.
        applyStimulus(1'b1, 32'd3, 32'd32, "store3");
        applyStimulus(1'b1, 32'd2, 32'd64, "store2");
        applyStimulus(1'b0, 32'd3, 32'd0, "load3");
        applyStimulus(1'b0, 32'd2, 32'd0, "load2");
        applyStimulus(1'b1, 32'd4, 32'd7, "store4 hold");
        applyStimulus(1'b0, 32'd4, 32'd0, "load4");

        // Out-of-range load and store at the first illegal index.
        applyStimulus(1'b0, 32'd32, 32'd0, "oor load");
        applyStimulus(1'b1, 32'd32, 32'hCAFE_F00D, "oor store");
        applyStimulus(1'b1, 32'h8000_0001, 32'h1234_5678, "oor store hi");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'(i), 32'd0, "verify");
        end

`ifdef DMEM_WAIT_EN
        // Abort a store while it is in WAIT. The outputs clear at once, no
        // pulse follows, and index 5 keeps its value.
        applyStimulus(1'b0, 32'd6, 32'd0, "pre-abort load");
        @(negedge i_clk);
        i_req = 1'b1;
        i_we = 1'b1;
        i_addr = 32'd5;
        i_write_data = 32'hDEAD_BEEF;
        @(posedge i_clk);
        #2;
        reset = 1'b0;
        i_req = 1'b0;
        #1;
        checkOutput("abort ready", 32'(o_ready), 32'd0);
        checkOutput("abort err", 32'(o_err), 32'd0);
        checkOutput("abort rdata", o_read_data, 32'd0);
        lastRead = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            checkOutput("abort no pulse", 32'(o_ready), 32'd0);
        end
        @(negedge i_clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
            checkOutput("post-abort no pulse", 32'(o_ready), 32'd0);
        end
        applyStimulus(1'b0, 32'd5, 32'd0, "index5 kept");
`endif

        // Drop reset while o_ready is high. The outputs clear without a clock edge.
        @(negedge i_clk);
        i_req = 1'b1;
        i_we = 1'b0;
        i_addr = 32'd7;
        waitEdges = 0;
        do begin
            @(posedge i_clk);
            #1;
            waitEdges++;
        end while (!o_ready && waitEdges < 20);
        checkOutput("arst pre ready", 32'(o_ready), 32'd1);
        checkOutput("arst pre rdata", o_read_data, expMem[7]);
        #1;
        reset = 1'b0;
        i_req = 1'b0;
        #1;
        checkOutput("arst ready", 32'(o_ready), 32'd0);
        checkOutput("arst err", 32'(o_err), 32'd0);
        checkOutput("arst rdata", o_read_data, 32'd0);
        lastRead = '0;
        @(negedge i_clk);
        reset = 1'b1;

        // Hold i_req high across two loads. There must be two pulses with an IDLE cycle between them.
        first = -1;
        second = -1;
        pulses = 0;
        @(negedge i_clk);
        i_req = 1'b1;
        i_we = 1'b0;
        i_addr = 32'd2;
        for (int e = 1; e <= 2 * LAT + 6; e++) begin
            @(posedge i_clk);
            #1;
            if (o_ready) begin
                pulses++;
                if (first < 0) first = e;
                else if (second < 0) second = e;
                checkOutput("b2b rdata", o_read_data, expMem[2]);
            end
            if (e == 2 * LAT + 1) i_req = 1'b0;
        end
        checkOutput("b2b pulses", 32'(pulses), 32'd2);
        checkOutput("b2b first", 32'(first), 32'(LAT));
        checkOutput("b2b second", 32'(second), 32'(2 * LAT + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 32: number of 32-bit data words held.
REQ-002 Parameter WAIT, default 2, range 0-15: wait states inserted per access when DMEM_WAIT_EN is defined.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  access request from the datapath; held high until o_ready is seen.
REQ-006 i_we  input  1  1 = store (sw), 0 = load (lw); sampled with i_req.
REQ-007 i_addr  input  32  word index; driven from datapath o_alu.
REQ-008 i_write_data  input  32  store data; driven from datapath o_write_data.
REQ-009 o_read_data  output  32  load result; returned to datapath i_read_data.
REQ-010 o_ready  output  1  one-cycle completion pulse.
REQ-011 o_err  output  1  out-of-range flag, valid only while o_ready is high.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-013 In IDLE, a rising edge with i_req=1 SHALL capture i_addr, i_we and i_write_data into internal registers (acceptance edge).
REQ-014 From IDLE on acceptance, the FSM SHALL go to WAIT if the effective wait count is >0, else to DONE.
REQ-015 In WAIT, a down-counter loaded with WAIT at acceptance SHALL decrement each cycle; on the edge where it reads 1, the FSM SHALL go to DONE.
REQ-016 o_ready SHALL be high for exactly the one cycle spent in DONE, i.e. the cycle after the (effective wait + 1)th edge counting the acceptance edge as the first; DONE SHALL always return to IDLE.
REQ-017 i_req and all inputs SHALL be ignored in WAIT and DONE; i_req still high in IDLE after DONE SHALL be treated as a new request.
REQ-018 Word index = captured address bits [log2(DEPTH)-1:0]; the address is in range iff all higher bits are 0.
REQ-019 Store in range: the array word SHALL be written on the edge entering DONE; o_read_data SHALL be unchanged.
REQ-020 Load in range: o_read_data SHALL be registered from the array on the edge entering DONE and held until the next completed load.
REQ-021 Out of range: no array write; a load SHALL return 0; o_err SHALL be 1 for the DONE cycle.
REQ-022 o_err SHALL be 0 whenever o_ready is 0.
REQ-023 A load following a store to the same index SHALL return the stored value, with no bypass hazard, since accesses are serialized.

Reset
REQ-024 Reset low SHALL force state IDLE, counter 0, o_ready=0, o_err=0, o_read_data=0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-access SHALL abort the access; no array write SHALL occur and no o_ready pulse SHALL follow.
REQ-026 Array contents SHALL NOT be reset; the first access after reset SHALL be accepted on the first rising edge with reset high and i_req=1.

Configuration
REQ-027 Macro DMEM_WAIT_EN defined: the effective wait count SHALL be WAIT, and the WAIT state and counter SHALL be present.
REQ-028 Macro DMEM_WAIT_EN undefined: the effective wait count SHALL be 0, the WAIT state and counter SHALL be omitted, and o_ready SHALL be high in the cycle after acceptance.

Verification
REQ-029 Store: i_we=1, i_addr=1, i_write_data=96 -> single o_ready pulse with o_err=0; a later load from index 1 returns 96.
REQ-030 Latency: with DMEM_WAIT_EN and WAIT=2, o_ready rises exactly 3 cycles after the acceptance edge; without the macro, 1 cycle after.
REQ-031 Loads: store 32 to index 3 and 64 to index 2, then load index 3 -> 32 and load index 2 -> 64; o_read_data holds 64 across a following store.
REQ-032 Range: load from i_addr=32 (DEPTH=32) -> o_err=1 and o_read_data=0; store to i_addr=32 leaves indices 0-31 unchanged.
REQ-033 Reset: drop reset during WAIT of a store of 0xDEADBEEF to index 5 -> outputs go to 0 asynchronously, no o_ready pulse, index 5 keeps its old value.
REQ-034 Back-to-back: i_req held high across two accesses -> two o_ready pulses separated by at least one IDLE cycle.
